// File: rtl/vital_alarm_manager.sv
// vital_alarm_manager: debounces four detector flags, timestamps each debounced rising edge and
// queues it in a FIFO drained over valid/ready. Escalation only with VITAL_ALARM_ESCALATION_EN.

module vital_alarm_channel #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ESCALATE_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flag,
   output logic active,
   output logic rise,
   output logic escalate
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);

   logic [DW-1:0] debCnt;
   logic          activeQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         debCnt  <= '0;
         active  <= 1'b0;
         activeQ <= 1'b0;
      end else begin
         activeQ <= active;
         if (!flag) begin
            debCnt <= '0;
            active <= 1'b0;
         end else begin
            if (debCnt != DEB_MAX) debCnt <= debCnt + 1'b1;
            if (debCnt >= DEB_MAX - 1'b1) active <= 1'b1;
         end
      end
   end

   // One-cycle pulse the clock after the debounced bit rises.
   assign rise = active & ~activeQ;

`ifdef VITAL_ALARM_ESCALATION_EN
   localparam int EW = $clog2(ESCALATE_CYCLES + 1);
   localparam logic [EW-1:0] ESC_MAX = EW'(ESCALATE_CYCLES);

   logic [EW-1:0] escCnt;

   // Cleared off the raw flag so escalate drops on the same edge as the debounced bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         escCnt   <= '0;
         escalate <= 1'b0;
      end else if (!flag) begin
         escCnt   <= '0;
         escalate <= 1'b0;
      end else if (active) begin
         if (escCnt != ESC_MAX) escCnt <= escCnt + 1'b1;
         if (escCnt >= ESC_MAX - 1'b1) escalate <= 1'b1;
      end
   end
`else
   assign escalate = 1'b0;
`endif
endmodule

module vital_alarm_manager #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 8,
   parameter int TS_W            = 16,
   parameter int ESCALATE_CYCLES = 1000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          fall_flag,
   input  logic                          pressure_flag,
   input  logic                          blood_flag,
   input  logic                          temp_flag,
   input  logic                          alarm_ready,
   input  logic                          overflow_clr,
   output logic                          alarm_valid,
   output logic [1:0]                    alarm_code,
   output logic [TS_W-1:0]               alarm_ts,
   output logic [3:0]                    active_alarms,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [3:0]                    escalate
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [1:0]      code;
      logic [TS_W-1:0] ts;
   } alarmEvent_t;

   logic [3:0]      flags, rise, pend, grant, grantEff;
   logic [1:0]      winCode;
   logic [TS_W-1:0] tsCnt;
   logic [AW-1:0]   wrPtr, rdPtr;
   logic [AW:0]     count;
   logic            full, push, pop, ovfSet;
   alarmEvent_t     mem [FIFO_DEPTH];
   alarmEvent_t     headEvt;

   assign flags = {temp_flag, blood_flag, pressure_flag, fall_flag};

   for (genvar gi = 0; gi < 4; gi++) begin : gChan
      vital_alarm_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ESCALATE_CYCLES (ESCALATE_CYCLES)
      ) uChan (
         .clk      (clk),
         .rst_n    (rst_n),
         .flag     (flags[gi]),
         .active   (active_alarms[gi]),
         .rise     (rise[gi]),
         .escalate (escalate[gi])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tsCnt <= '0;
      else        tsCnt <= tsCnt + 1'b1;
   end

   // Lowest index wins: fall > pressure > blood > temperature.
   assign grant = pend & (~pend + 4'd1);

   always_comb begin
      winCode = 2'd3;
      if (pend[0])      winCode = 2'd0;
      else if (pend[1]) winCode = 2'd1;
      else if (pend[2]) winCode = 2'd2;
   end

   assign full     = (count == FULL_CNT);
   assign pop      = alarm_valid & alarm_ready;
   assign push     = (|pend) & (~full | pop);
   assign grantEff = push ? grant : 4'd0;
   // A rise on a channel whose previous event is still waiting (and not leaving now) is lost.
   assign ovfSet   = |(rise & pend & ~grantEff);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= '0;
         overflow <= 1'b0;
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
      end else begin
         pend <= (pend & ~grantEff) | rise;
         if (ovfSet)            overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= '{code: winCode, ts: tsCnt};
   end

   assign headEvt     = mem[rdPtr];
   assign alarm_valid = (count != '0);
   assign alarm_code  = alarm_valid ? headEvt.code : 2'd0;
   assign alarm_ts    = alarm_valid ? headEvt.ts : '0;
   assign fifo_count  = count;
endmodule

// File: tb/tb_vital_alarm_manager.sv
// Scoreboard bench for vital_alarm_manager: directed flag pulses push expected {code,ts}
// into a queue; a negedge monitor checks every popped head entry.

module tb_vital_alarm_manager;
   localparam int D  = 4;
   localparam int FD = 8;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fall_flag = 0, pressure_flag = 0, blood_flag = 0, temp_flag = 0;
   logic          alarm_ready = 0, overflow_clr = 0;
   logic          alarm_valid;
   logic [1:0]    alarm_code;
   logic [TW-1:0] alarm_ts;
   logic [3:0]    active_alarms;
   logic [3:0]    fifo_count;
   logic          overflow;
   logic [3:0]    escalate;

   int vectors = 0;
   int errs    = 0;
   logic [TW-1:0] cyc;
   logic [TW+1:0] sb[$];

   vital_alarm_manager #(
      .DEBOUNCE_CYCLES (D),
      .FIFO_DEPTH      (FD),
      .TS_W            (TW),
      .ESCALATE_CYCLES (20)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fall_flag     (fall_flag),
      .pressure_flag (pressure_flag),
      .blood_flag    (blood_flag),
      .temp_flag     (temp_flag),
      .alarm_ready   (alarm_ready),
      .overflow_clr  (overflow_clr),
      .alarm_valid   (alarm_valid),
      .alarm_code    (alarm_code),
      .alarm_ts      (alarm_ts),
      .active_alarms (active_alarms),
      .fifo_count    (fifo_count),
      .overflow      (overflow),
      .escalate      (escalate)
   );

   always #5 clk = ~clk;

   // Reference timestamp: value the DUT timestamp should hold between edges.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= '0;
      else        cyc <= cyc + 1'b1;
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && alarm_valid === 1'b1 && alarm_ready === 1'b1) begin
         vectors++;
         if (sb.size() == 0) begin
            errs++;
            $display("FAIL pop_unexpected: got code %0d ts %0d, scoreboard empty", alarm_code, alarm_ts);
         end else begin
            logic [TW+1:0] e;
            e = sb.pop_front();
            if ({alarm_code, alarm_ts} !== e) begin
               errs++;
               $display("FAIL pop_entry: got code %0d ts %0d expected code %0d ts %0d",
                        alarm_code, alarm_ts, e[TW+1:TW], e[TW-1:0]);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic setFlag(input int ch, input logic v);
      case (ch)
         0: fall_flag = v;
         1: pressure_flag = v;
         2: blood_flag = v;
         default: temp_flag = v;
      endcase
   endtask

   // Isolated D-cycle pulse; the push lands D+2 edges after the raise, stamped cyc+D+1.
   task automatic pulse(input int ch, input bit expectPush);
      if (expectPush) sb.push_back({2'(ch), TW'(cyc + TW'(D + 1))});
      setFlag(ch, 1'b1);
      step(D);
      setFlag(ch, 1'b0);
      step(3);
   endtask

   task automatic drain(input string name);
      alarm_ready = 1'b1;
      for (int i = 0; i < 40 && fifo_count != 0; i++) step(1);
      alarm_ready = 1'b0;
      step(1);
      chk(name, {28'd0, fifo_count}, 32'd0);
   endtask

   initial begin
      #12;
      chk("reset_valid", {31'd0, alarm_valid}, 0);
      chk("reset_count", {28'd0, fifo_count}, 0);
      chk("reset_ts", {16'd0, alarm_ts}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(2);

      // Short pressure pulse is filtered.
      pressure_flag = 1'b1;
      step(3);
      pressure_flag = 1'b0;
      step(1);
      chk("short_active", {28'd0, active_alarms}, 0);
      step(3);
      chk("short_count", {28'd0, fifo_count}, 0);

      // Full-length pressure pulse: active after D edges, valid after D+2.
      sb.push_back({2'd1, TW'(cyc + TW'(D + 1))});
      pressure_flag = 1'b1;
      step(D);
      chk("deb_active", {28'd0, active_alarms}, 32'h2);
      step(1);
      chk("lat_valid_early", {31'd0, alarm_valid}, 0);
      step(1);
      chk("lat_valid", {31'd0, alarm_valid}, 1);
      pressure_flag = 1'b0;
      drain("drain_pressure");

      // Fall and temperature together: fall first, temperature one stamp later.
      sb.push_back({2'd0, TW'(cyc + TW'(D + 1))});
      sb.push_back({2'd3, TW'(cyc + TW'(D + 2))});
      fall_flag = 1'b1;
      temp_flag = 1'b1;
      step(D);
      fall_flag = 1'b0;
      temp_flag = 1'b0;
      step(4);
      chk("simul_count", {28'd0, fifo_count}, 2);
      drain("drain_simul");

      // Backpressure: fill, hold a pending event, then lose a repeat.
      for (int i = 0; i < FD; i++) pulse(i % 4, 1'b1);
      chk("full_count", {28'd0, fifo_count}, FD);
      pulse(0, 1'b0);
      chk("held_count", {28'd0, fifo_count}, FD);
      chk("held_ovf", {31'd0, overflow}, 0);
      pulse(0, 1'b0);
      chk("repeat_ovf", {31'd0, overflow}, 1);
      sb.push_back({2'd0, cyc});
      alarm_ready = 1'b1;
      step(1);
      alarm_ready = 1'b0;
      chk("swap_count", {28'd0, fifo_count}, FD);

      // Overflow clear alone, then clear racing a new overflow.
      overflow_clr = 1'b1;
      step(1);
      overflow_clr = 1'b0;
      chk("ovf_clr", {31'd0, overflow}, 0);
      pulse(0, 1'b0);
      fall_flag = 1'b1;
      step(D);
      fall_flag = 1'b0;
      overflow_clr = 1'b1;
      step(1);
      overflow_clr = 1'b0;
      step(2);
      chk("ovf_set_wins", {31'd0, overflow}, 1);
      sb.push_back({2'd0, cyc});
      drain("drain_full");
      overflow_clr = 1'b1;
      step(1);
      overflow_clr = 1'b0;
      chk("ovf_clr2", {31'd0, overflow}, 0);

      // Reset mid-operation with queued entries and blood held high.
      for (int i = 0; i < 5; i++) pulse(i % 4, 1'b1);
      chk("pre_rst_count", {28'd0, fifo_count}, 5);
      blood_flag = 1'b1;
      step(D + 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'd0, alarm_valid}, 0);
      chk("rst_count", {28'd0, fifo_count}, 0);
      chk("rst_active", {28'd0, active_alarms}, 0);
      chk("rst_code_ts", {14'd0, alarm_code, alarm_ts}, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back({2'd2, TW'(D + 1)});
      step(D + 1);
      chk("rst_blood_early", {31'd0, alarm_valid}, 0);
      step(1);
      chk("rst_blood_valid", {31'd0, alarm_valid}, 1);
      blood_flag = 1'b0;
      drain("drain_blood");

`ifdef VITAL_ALARM_ESCALATION_EN
      sb.push_back({2'd3, TW'(cyc + TW'(D + 1))});
      temp_flag = 1'b1;
      step(D);
      chk("esc_active", {28'd0, active_alarms}, 32'h8);
      step(19);
      chk("esc_early", {28'd0, escalate}, 0);
      step(1);
      chk("esc_set", {28'd0, escalate}, 32'h8);
      temp_flag = 1'b0;
      step(1);
      chk("esc_clr", {28'd0, escalate}, 0);
      chk("esc_active_clr", {28'd0, active_alarms}, 0);
      drain("drain_esc");
`else
      temp_flag = 1'b1;
      step(D + 3);
      chk("esc_tied", {28'd0, escalate}, 0);
      temp_flag = 1'b0;
      sb.push_back({2'd3, TW'(cyc - TW'(D + 3) + TW'(D + 1))});
      drain("drain_esc");
`endif

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/vital_alarm_manager.md
Name: vital_alarm_manager

Overview:
- Sequential stage directly downstream of the first-phase healthcare detectors.
- Consumes the four combinational abnormality flags (fall, pressure, blood, temperature) and debounces each one.
- Turns each debounced rising edge into a timestamped alarm event and queues the events in a FIFO.
- Drains the FIFO to the reporting/phase-two logic over a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive sampled-high clocks required before a flag counts as debounced (>=1).
- FIFO_DEPTH, 8, event queue entries (power of 2, >=2).
- TS_W, 16, timestamp counter width.
- ESCALATE_CYCLES, 1000, continuous debounced-high clocks before escalation (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fall_flag  in  1  raw fall-detected flag.
- pressure_flag  in  1  raw pressure abnormality flag.
- blood_flag  in  1  raw blood abnormality flag.
- temp_flag  in  1  raw temperature abnormality flag.
- alarm_ready  in  1  consumer accepts head entry.
- overflow_clr  in  1  clears sticky overflow.
- alarm_valid  out  1  FIFO non-empty.
- alarm_code  out  2  head event code: 0 fall, 1 pressure, 2 blood, 3 temperature.
- alarm_ts  out  TS_W  head event timestamp.
- active_alarms  out  4  debounced flags {temp,blood,pressure,fall}.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky lost-event indicator.
- escalate  out  4  per-channel escalation (optional feature; tied 0 when disabled).

Behaviour:
- Reset (async, rst_n=0): every output 0, all counters, pending bits and FIFO pointers cleared, timestamp 0. Reset mid-operation discards queued events; nothing survives it.
- Timestamp: free-running TS_W counter, +1 per clock, wraps to 0.
- Debounce, per channel:
  - Flag sampled 1: counter increments, saturating at DEBOUNCE_CYCLES.
  - Flag sampled 0: counter and debounced bit clear on that edge.
  - Debounced bit is registered and goes 1 on the edge where the counter reaches DEBOUNCE_CYCLES (raw high at edge k..k+D-1 -> active high after edge k+D-1).
- Pending: a debounced 0->1 transition sets that channel's pending bit on the following edge.
- Arbitration and push:
  - Each clock at most one push. Priority fall > pressure > blood > temperature.
  - Push allowed when the FIFO is not full, or is full but popping this cycle.
  - A push writes {code, current timestamp} and clears the winning pending bit.
  - A pending bit blocked by a full FIFO is held, not dropped.
- Overflow:
  - A new debounced rising edge on a channel whose pending bit is still set sets overflow; that event is lost.
  - overflow_clr clears overflow. Set wins over simultaneous clear.
- FIFO:
  - No fall-through: a push into an empty FIFO gives alarm_valid=1 on the next cycle.
  - Pop on alarm_valid&&alarm_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - alarm_code and alarm_ts hold stable while alarm_valid=1 and alarm_ready=0.
- Latency: raw flag first high to alarm_valid = DEBOUNCE_CYCLES+2 clocks with an empty FIFO and no competing channel.

Optional Feature:
- Macro: VITAL_ALARM_ESCALATION_EN.
- Defined: per-channel counter counts clocks while the debounced bit is 1, saturating.
  - escalate[i] goes 1 when the count reaches ESCALATE_CYCLES and stays 1 until the debounced bit drops; it clears on that same edge.
  - Escalation does not push FIFO entries.
- Undefined: no escalation counters are built; escalate is constant 0.

Test Plan:
- Debounce, DEBOUNCE_CYCLES=4: pressure_flag high 3 clocks then low -> no event, active_alarms=0. Then high 4 clocks -> active_alarms=4'b0010, one entry code 1, alarm_valid 6 clocks after the first high.
- Simultaneous: fall_flag and temp_flag rise on the same edge -> code 0 queued first, code 3 one cycle later with timestamp +1. Drain with alarm_ready=1 -> order 0 then 3.
- Backpressure, FIFO_DEPTH=8, alarm_ready=0: generate 8 events -> fifo_count=8. A 9th distinct-channel edge stays pending; a repeat edge on the same channel -> overflow=1. Raise alarm_ready for 1 cycle -> pending event enters the same cycle it frees, count stays 8.
- Overflow clear: assert overflow_clr alone -> overflow=0. Assert it on the same cycle as a new overflow -> overflow stays 1.
- Reset mid-operation: rst_n=0 with 5 queued entries and blood_flag held high -> outputs 0 immediately. After release the blood event re-debounces and appears as a fresh entry.
- Escalation (macro defined, ESCALATE_CYCLES=20): temp_flag held high -> escalate[3]=1 twenty clocks after active_alarms[3] rises. Drop temp_flag -> escalate[3]=0 on the same edge the debounced bit clears.
